out_port_dec_display: RTL and testbench

- Downstream consumer of the single-cycle computer's 32-bit output port.
- Converts the port value to six decimal digits with a sequential shift-add-3 (double-dabble) engine.
- Drives the six active-low 7-segment displays hex5..hex0.
- Runs on the CPU clock domain; the input needs no synchroniser.

---
 rtl/out_port_dec_display.sv | 179 +++++++++++++++++
 tb/tb_out_port_dec_display.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/out_port_dec_display.sv
// Converts the CPU output port to six decimal digits with a sequential
// double-dabble engine and drives six active-low 7-segment displays.
module out_port_dec_display #(
   parameter int LEADING_BLANK = 1,
   parameter int RESET_BLANK   = 1
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic [31:0] out_port,
   output logic [6:0]  hex0,
   output logic [6:0]  hex1,
   output logic [6:0]  hex2,
   output logic [6:0]  hex3,
   output logic [6:0]  hex4,
   output logic [6:0]  hex5,
   output logic        busy,
   output logic        done,
   output logic        ovf
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_LATCH = 2'd2
   } state_t;

   localparam logic [6:0]  SEG_BLANK = 7'b1111111;
   localparam logic [6:0]  SEG_DASH  = 7'b0111111;
   localparam logic [6:0]  SEG_RST   = (RESET_BLANK != 0) ? 7'h7F : 7'h40;
   localparam logic [31:0] MAX_DEC   = 32'd999999;

   function automatic logic [6:0] seg7(input logic [3:0] digit);
      case (digit)
         4'd0:    seg7 = 7'b1000000;
         4'd1:    seg7 = 7'b1111001;
         4'd2:    seg7 = 7'b0100100;
         4'd3:    seg7 = 7'b0110000;
         4'd4:    seg7 = 7'b0011001;
         4'd5:    seg7 = 7'b0010010;
         4'd6:    seg7 = 7'b0000010;
         4'd7:    seg7 = 7'b1111000;
         4'd8:    seg7 = 7'b0000000;
         4'd9:    seg7 = 7'b0010000;
         default: seg7 = SEG_BLANK;
      endcase
   endfunction

   state_t      state_r, state_nxt_s;
   logic [31:0] last_val_r;
   logic        force_r;
   logic        conv_ovf_r;
   logic [19:0] bin_r;
   logic [23:0] bcd_r;
   logic [23:0] adj_s;
   logic [4:0]  cnt_r;
   logic        trig_s, load_s, shift_s, latch_s, busy_nxt_s, done_nxt_s;
   logic [6:0]  seg_nxt_s [6];
   logic [6:0]  hex_r [6];
   logic        busy_r, done_r, ovf_r;

   assign trig_s = (out_port != last_val_r) || force_r;

   // State register
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (trig_s) state_nxt_s = ST_SHIFT;
            else        state_nxt_s = ST_IDLE;
         end
         ST_SHIFT: begin
            if (cnt_r == 5'd19) state_nxt_s = ST_LATCH;
            else                state_nxt_s = ST_SHIFT;
         end
         ST_LATCH: state_nxt_s = ST_IDLE;
         default:  state_nxt_s = ST_IDLE;
      endcase
   end

   // Per-state control strobes and next values of the registered flags
   always_comb begin
      load_s     = 1'b0;
      shift_s    = 1'b0;
      latch_s    = 1'b0;
      case (state_r)
         ST_IDLE:  load_s  = trig_s;
         ST_SHIFT: shift_s = 1'b1;
         ST_LATCH: latch_s = 1'b1;
         default:  load_s  = 1'b0;
      endcase
      busy_nxt_s = (state_nxt_s != ST_IDLE);
      done_nxt_s = latch_s;
   end

   // Add-3 correction of every BCD nibble ahead of the shift
   always_comb begin
      adj_s = 24'h0;
      for (int j = 0; j < 6; j++) begin
         if (bcd_r[4*j +: 4] >= 4'd5) adj_s[4*j +: 4] = bcd_r[4*j +: 4] + 4'd3;
         else                         adj_s[4*j +: 4] = bcd_r[4*j +: 4];
      end
   end

   // Segment images for the finished conversion, with leading-zero blanking
   always_comb begin
      logic lz;
      lz = 1'b1;
      for (int i = 5; i >= 0; i--) begin
         lz = lz && (bcd_r[4*i +: 4] == 4'd0);
         if (conv_ovf_r)                              seg_nxt_s[i] = SEG_DASH;
         else if ((LEADING_BLANK != 0) && (i > 0) && lz) seg_nxt_s[i] = SEG_BLANK;
         else                                         seg_nxt_s[i] = seg7(bcd_r[4*i +: 4]);
      end
   end

   // Conversion datapath: capture on trigger, shift-add-3 while shifting
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         last_val_r <= 32'h0;
         force_r    <= 1'b1;
         conv_ovf_r <= 1'b0;
         bin_r      <= 20'h0;
         bcd_r      <= 24'h0;
         cnt_r      <= 5'd0;
      end else if (load_s) begin
         last_val_r <= out_port;
         force_r    <= 1'b0;
         conv_ovf_r <= (out_port > MAX_DEC);
         bin_r      <= out_port[19:0];
         bcd_r      <= 24'h0;
         cnt_r      <= 5'd0;
      end else if (shift_s) begin
         bcd_r      <= {adj_s[22:0], bin_r[19]};
         bin_r      <= {bin_r[18:0], 1'b0};
         cnt_r      <= cnt_r + 5'd1;
      end else begin
         cnt_r      <= cnt_r;
      end
   end

   // Registered outputs; the display only changes on the LATCH edge
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < 6; i++) hex_r[i] <= SEG_RST;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         ovf_r  <= 1'b0;
      end else begin
         busy_r <= busy_nxt_s;
         done_r <= done_nxt_s;
         if (latch_s) begin
            for (int i = 0; i < 6; i++) hex_r[i] <= seg_nxt_s[i];
            ovf_r <= conv_ovf_r;
         end else begin
            ovf_r <= ovf_r;
         end
      end
   end

   assign hex0 = hex_r[0];
   assign hex1 = hex_r[1];
   assign hex2 = hex_r[2];
   assign hex3 = hex_r[3];
   assign hex4 = hex_r[4];
   assign hex5 = hex_r[5];
   assign busy = busy_r;
   assign done = done_r;
   assign ovf  = ovf_r;

endmodule

// File: tb/tb_out_port_dec_display.sv
// Directed self-checking bench for out_port_dec_display: one instance with
// default parameters, one with all six digits shown and "0" reset value.
module tb_out_port_dec_display;

   localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
   localparam logic [6:0] S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010;
   localparam logic [6:0] S6 = 7'b0000010, S7 = 7'b1111000, S9 = 7'b0010000;
   localparam logic [6:0] BL = 7'b1111111, DS = 7'b0111111, RZ = 7'h40;

   logic        clock = 1'b0;
   logic        resetn;
   logic [31:0] out_port;
   logic [6:0]  a0, a1, a2, a3, a4, a5, b0, b1, b2, b3, b4, b5;
   logic        busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
   logic [41:0] hex_a, hex_b;

   int n_checks = 0;
   int n_errors = 0;

   assign hex_a = {a5, a4, a3, a2, a1, a0};
   assign hex_b = {b5, b4, b3, b2, b1, b0};

   always #5 clock = ~clock;

   out_port_dec_display dut_a (
      .clock(clock), .resetn(resetn), .out_port(out_port),
      .hex0(a0), .hex1(a1), .hex2(a2), .hex3(a3), .hex4(a4), .hex5(a5),
      .busy(busy_a), .done(done_a), .ovf(ovf_a)
   );

   out_port_dec_display #(.LEADING_BLANK(0), .RESET_BLANK(0)) dut_b (
      .clock(clock), .resetn(resetn), .out_port(out_port),
      .hex0(b0), .hex1(b1), .hex2(b2), .hex3(b3), .hex4(b4), .hex5(b5),
      .busy(busy_b), .done(done_b), .ovf(ovf_b)
   );

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Present a value, take the trigger edge, then count edges up to done.
   task automatic convert(input logic [31:0] v, output int lat, output int busy_cnt);
      out_port = v;
      lat      = 0;
      busy_cnt = 0;
      tick();
      if (busy_a) busy_cnt++;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (busy_a) busy_cnt++;
         if (done_a) begin
            lat = k;
            break;
         end
      end
   endtask

   initial begin
      int lat, bc, done_cnt, busy2;
      resetn   = 1'b0;
      out_port = 32'h21;
      repeat (3) tick();
      check_eq("rst_hex_a", 64'(hex_a), 64'({6{BL}}));
      check_eq("rst_hex_b", 64'(hex_b), 64'({6{RZ}}));
      check_eq("rst_busy", 64'(busy_a), 64'd0);
      check_eq("rst_done", 64'(done_a), 64'd0);
      check_eq("rst_ovf", 64'(ovf_a), 64'd0);

      resetn = 1'b1;
      convert(32'h21, lat, bc);
      check_eq("lat_33", 64'(lat), 64'd21);
      check_eq("busy_33", 64'(bc), 64'd21);
      check_eq("hex_33", 64'(hex_a), 64'({BL, BL, BL, BL, S3, S3}));
      check_eq("hexb_33", 64'(hex_b), 64'({S0, S0, S0, S0, S3, S3}));
      check_eq("ovf_33", 64'(ovf_a), 64'd0);
      tick();
      check_eq("done_pulse_33", 64'(done_a), 64'd0);

      convert(32'd123456, lat, bc);
      check_eq("lat_123456", 64'(lat), 64'd21);
      check_eq("busy_123456", 64'(bc), 64'd21);
      check_eq("hex_123456", 64'(hex_a), 64'({S1, S2, S3, S4, S5, S6}));
      bc = 0;
      done_cnt = 0;
      for (int k = 0; k < 5; k++) begin
         tick();
         if (busy_a) bc++;
         if (done_a) done_cnt++;
      end
      check_eq("idle_busy", 64'(bc), 64'd0);
      check_eq("idle_done", 64'(done_cnt), 64'd0);
      check_eq("idle_hex", 64'(hex_a), 64'({S1, S2, S3, S4, S5, S6}));

      convert(32'd999999, lat, bc);
      check_eq("hex_999999", 64'(hex_a), 64'({6{S9}}));
      check_eq("ovf_999999", 64'(ovf_a), 64'd0);
      convert(32'd1000000, lat, bc);
      check_eq("lat_1000000", 64'(lat), 64'd21);
      check_eq("hex_1000000", 64'(hex_a), 64'({6{DS}}));
      check_eq("ovf_1000000", 64'(ovf_a), 64'd1);
      convert(32'h8000_0005, lat, bc);
      check_eq("lat_hi_bit", 64'(lat), 64'd21);
      check_eq("hex_hi_bit", 64'(hex_a), 64'({6{DS}}));
      check_eq("ovf_hi_bit", 64'(ovf_a), 64'd1);

      convert(32'd0, lat, bc);
      check_eq("hex_0", 64'(hex_a), 64'({BL, BL, BL, BL, BL, S0}));
      check_eq("hexb_0", 64'(hex_b), 64'({6{S0}}));
      check_eq("ovf_0", 64'(ovf_a), 64'd0);
      convert(32'd42, lat, bc);
      check_eq("hex_42", 64'(hex_a), 64'({BL, BL, BL, BL, S4, S2}));
      check_eq("hexb_42", 64'(hex_b), 64'({S0, S0, S0, S0, S4, S2}));

      // Change 77 -> 5 mid-conversion
      out_port = 32'd77;
      tick();
      done_cnt = 0;
      busy2    = 0;
      for (int k = 1; k <= 50; k++) begin
         tick();
         if (k == 10) out_port = 32'd5;
         if (k >= 22 && busy_a) busy2++;
         if (k < 21) begin
            if (hex_a !== {BL, BL, BL, BL, S4, S2}) check_eq("hex_hold_42", 64'(hex_a), 64'({BL, BL, BL, BL, S4, S2}));
         end
         if (done_a) begin
            done_cnt++;
            if (done_cnt == 1) begin
               check_eq("lat_77", 64'(k), 64'd21);
               check_eq("hex_77", 64'(hex_a), 64'({BL, BL, BL, BL, S7, S7}));
            end else begin
               check_eq("lat_5", 64'(k), 64'd43);
               check_eq("hex_5", 64'(hex_a), 64'({BL, BL, BL, BL, BL, S5}));
            end
         end
      end
      check_eq("done_cnt_77_5", 64'(done_cnt), 64'd2);
      check_eq("busy2_77_5", 64'(busy2), 64'd21);
      check_eq("hex_final_5", 64'(hex_a), 64'({BL, BL, BL, BL, BL, S5}));

      // Reset in SHIFT cycle 8 of 654321
      out_port = 32'd654321;
      tick();
      repeat (8) tick();
      check_eq("busy_mid", 64'(busy_a), 64'd1);
      resetn = 1'b0;
      #1;
      check_eq("mid_rst_hex", 64'(hex_a), 64'({6{BL}}));
      check_eq("mid_rst_busy", 64'(busy_a), 64'd0);
      check_eq("mid_rst_hexb", 64'(hex_b), 64'({6{RZ}}));
      @(posedge clock);
      #1;
      resetn = 1'b1;
      convert(32'd654321, lat, bc);
      check_eq("lat_654321", 64'(lat), 64'd21);
      check_eq("hex_654321", 64'(hex_a), 64'({S6, S5, S4, S3, S2, S1}));
      check_eq("ovf_654321", 64'(ovf_a), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
